// File: rtl/pll_lock_mgr.sv
// PLL supervisor: pulses pll_sys reset, filters the asynchronous lock and sequences sys_rst.
// Optional macro PLL_LOCK_MGR_STATS_EN adds a saturating lock-loss counter port.
module pll_lock_mgr #(
    parameter int unsigned PLL_RST_CYC  = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned LOCK_FILT    = 64,
    parameter int unsigned RST_HOLD     = 32,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_in,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic       lock_lost,
`ifdef PLL_LOCK_MGR_STATS_EN
    output logic [7:0] lock_loss_cnt,
`endif
    output logic [2:0] state_o
);

    localparam int unsigned MaxA = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
    localparam int unsigned MaxB = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
    localparam int unsigned MaxP = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned TW   = $clog2(MaxP) + 1;

    localparam logic [TW-1:0] RstLast  = TW'(PLL_RST_CYC - 1);
    localparam logic [TW-1:0] ToLast   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] FiltLast = TW'(LOCK_FILT - 1);
    localparam logic [TW-1:0] HoldLast = TW'(RST_HOLD - 1);
    localparam logic [3:0]    RetryMax = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StFilter   = 3'd2,
        StHold     = 3'd3,
        StRun      = 3'd4,
        StFail     = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_cnt_q, retry_cnt_d;
    logic [3:0]    retry_inc;
    logic          lock_meta_q, lock_s_q;
    logic          lost_evt;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          pll_ready_q, pll_ready_d;
    logic          pll_fail_q, pll_fail_d;
    logic          lock_lost_q, lock_lost_d;

    // State register, lock synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StResetPll;
            timer_q     <= '0;
            retry_cnt_q <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            pll_fail_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_cnt_q <= retry_cnt_d;
            lock_meta_q <= pll_lock_in;
            lock_s_q    <= lock_meta_q;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            pll_ready_q <= pll_ready_d;
            pll_fail_q  <= pll_fail_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign retry_inc = retry_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        lost_evt    = 1'b0;
        timer_d     = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        unique case (state_q)
            StResetPll: begin
                if (timer_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lock_s_q) begin
                    state_d = StFilter;
                end else if (timer_q == ToLast) begin
                    retry_cnt_d = retry_inc;
                    state_d     = (retry_inc == RetryMax) ? StFail : StResetPll;
                end
            end
            StFilter: begin
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                end else if (timer_q == FiltLast) begin
                    state_d     = StHold;
                    retry_cnt_d = '0;
                end
            end
            StHold: begin
                if (!lock_s_q) begin
                    state_d  = StResetPll;
                    lost_evt = 1'b1;
                end else if (timer_q == HoldLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!lock_s_q) begin
                    state_d  = StResetPll;
                    lost_evt = 1'b1;
                end
            end
            StFail: begin
                if (retry_req) begin
                    state_d     = StResetPll;
                    retry_cnt_d = '0;
                end
            end
            default: state_d = StResetPll;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    // Outputs decode the next state so they line up with state_o after the edge.
    always_comb begin
        pll_rst_d   = (state_d == StResetPll) || (state_d == StFail);
        sys_rst_d   = (state_d != StRun);
        pll_ready_d = (state_d == StRun);
        pll_fail_d  = (state_d == StFail);
        lock_lost_d = lost_evt;
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign pll_ready = pll_ready_q;
    assign pll_fail  = pll_fail_q;
    assign lock_lost = lock_lost_q;
    assign state_o   = state_q;

`ifdef PLL_LOCK_MGR_STATS_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lost_evt && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) loss_cnt_q <= '0;
        else     loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule
